// File: rtl/serial_add_arb_pkg.sv
// Shared types and constants for the serial_add_arb slice.
// Optional macro SERIAL_ADD_OVF_EN (see serial_add_arb) enables the overflow output.
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int unsigned DEFAULT_WIDTH = 8;
    localparam int unsigned CNT_W_DEFAULT = $clog2(DEFAULT_WIDTH);

    // Bit-counter width for a given operand width; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned w);
        return (w > 1) ? int'($clog2(w)) : 1;
    endfunction

endpackage

// File: rtl/serial_add_arb_if.sv
// Requester-side bus of serial_add_arb: requests, operands, grants and results.
// With SERIAL_ADD_OVF_EN defined the bus also carries the signed overflow flag.
interface serial_add_arb_if #(
    parameter int unsigned WIDTH = 8
);
    logic [1:0]       req;
    logic [WIDTH-1:0] a0;
    logic [WIDTH-1:0] b0;
    logic             cin0;
    logic [WIDTH-1:0] a1;
    logic [WIDTH-1:0] b1;
    logic             cin1;
    logic [1:0]       gnt;
    logic             busy;
    logic             done;
    logic             done_id;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef SERIAL_ADD_OVF_EN
    logic             ovf;
`endif

`ifdef SERIAL_ADD_OVF_EN
    modport master (
        output req, a0, b0, cin0, a1, b1, cin1,
        input  gnt, busy, done, done_id, sum, cout, ovf
    );
    modport slave (
        input  req, a0, b0, cin0, a1, b1, cin1,
        output gnt, busy, done, done_id, sum, cout, ovf
    );
`else
    modport master (
        output req, a0, b0, cin0, a1, b1, cin1,
        input  gnt, busy, done, done_id, sum, cout
    );
    modport slave (
        input  req, a0, b0, cin0, a1, b1, cin1,
        output gnt, busy, done, done_id, sum, cout
    );
`endif

endinterface

// File: rtl/serial_add_arb_fa_cell.sv
// Single 1-bit full adder; the only arithmetic resource of serial_add_arb.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ cin;
    assign co = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_add_arb.sv
// Two-requester round-robin arbiter in front of a bit-serial (LSB first) adder.
// Define SERIAL_ADD_OVF_EN to add the signed-overflow output bus.ovf.
module serial_add_arb
    import serial_add_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input logic           clk,
    input logic           rst,
    serial_add_arb_if.slave bus
);

    localparam int unsigned CNT_W = cnt_width(WIDTH);

    state_e           state_q, state_d;
    logic             ptr_q, ptr_d;
    logic             id_q, id_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             c_q, c_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       gnt_q, gnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             done_id_q, done_id_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
`ifdef SERIAL_ADD_OVF_EN
    logic             ovf_raw_q, ovf_raw_d;
    logic             ovf_q, ovf_d;
`endif

    logic sel;
    logic fa_s;
    logic fa_co;

    fa_cell u_fa (
        .a   (a_q[0]),
        .b   (b_q[0]),
        .cin (c_q),
        .s   (fa_s),
        .co  (fa_co)
    );

    // Pointer only breaks ties; a lone request always wins.
    assign sel = (bus.req == 2'b11) ? ptr_q : bus.req[1];

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        id_d      = id_q;
        a_d       = a_q;
        b_d       = b_q;
        s_d       = s_q;
        c_d       = c_q;
        cnt_d     = cnt_q;
        gnt_d     = '0;
        busy_d    = busy_q;
        done_d    = 1'b0;
        done_id_d = done_id_q;
        sum_d     = sum_q;
        cout_d    = cout_q;
`ifdef SERIAL_ADD_OVF_EN
        ovf_raw_d = ovf_raw_q;
        ovf_d     = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.req != 2'b00) begin
                    id_d    = sel;
                    a_d     = sel ? bus.a1 : bus.a0;
                    b_d     = sel ? bus.b1 : bus.b0;
                    c_d     = sel ? bus.cin1 : bus.cin0;
                    s_d     = '0;
                    cnt_d   = '0;
                    gnt_d   = sel ? 2'b10 : 2'b01;
                    busy_d  = 1'b1;
                    ptr_d   = ~sel;
                    state_d = RUN;
                end
            end
            RUN: begin
                s_d   = {fa_s, s_q[WIDTH-1:1]};
                c_d   = fa_co;
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
`ifdef SERIAL_ADD_OVF_EN
                    // c_q here is the carry into the MSB.
                    ovf_raw_d = c_q ^ fa_co;
`endif
                    busy_d  = 1'b0;
                    state_d = DONE;
                end
            end
            DONE: begin
                done_d    = 1'b1;
                done_id_d = id_q;
                sum_d     = s_q;
                cout_d    = c_q;
`ifdef SERIAL_ADD_OVF_EN
                ovf_d     = ovf_raw_q;
`endif
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= 1'b0;
            id_q      <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            s_q       <= '0;
            c_q       <= 1'b0;
            cnt_q     <= '0;
            gnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            done_id_q <= 1'b0;
            sum_q     <= '0;
            cout_q    <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            ovf_raw_q <= 1'b0;
            ovf_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            id_q      <= id_d;
            a_q       <= a_d;
            b_q       <= b_d;
            s_q       <= s_d;
            c_q       <= c_d;
            cnt_q     <= cnt_d;
            gnt_q     <= gnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            done_id_q <= done_id_d;
            sum_q     <= sum_d;
            cout_q    <= cout_d;
`ifdef SERIAL_ADD_OVF_EN
            ovf_raw_q <= ovf_raw_d;
            ovf_q     <= ovf_d;
`endif
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.done_id = done_id_q;
    assign bus.sum     = sum_q;
    assign bus.cout    = cout_q;
`ifdef SERIAL_ADD_OVF_EN
    assign bus.ovf     = ovf_q;
`endif

endmodule

// File: tb/tb_serial_add_arb.sv
// Self-checking bench for serial_add_arb against an arithmetic/arbitration reference model.
module tb_serial_add_arb;

    localparam int unsigned W = 8;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   mptr   = 0;

    serial_add_arb_if #(.WIDTH(W)) bus ();

    serial_add_arb #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    endfunction

`ifdef SERIAL_ADD_OVF_EN
    function automatic logic ref_ovf(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        int s;
        s = int'($signed(a)) + int'($signed(b)) + int'(c);
        return (s > (2 ** (W - 1)) - 1) || (s < -(2 ** (W - 1)));
    endfunction
`endif

    task automatic test_reset;
        bus.req = '0;
        bus.a0 = '0; bus.b0 = '0; bus.cin0 = 1'b0;
        bus.a1 = '0; bus.b1 = '0; bus.cin1 = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (bus.gnt !== 2'b00) begin errors++; $display("FAIL reset_gnt: got %b want 00", bus.gnt); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.done); end
        checks++; if (bus.done_id !== 1'b0) begin errors++; $display("FAIL reset_done_id: got %b want 0", bus.done_id); end
        checks++; if ({bus.cout, bus.sum} !== '0) begin errors++; $display("FAIL reset_sum: got %h want 0", {bus.cout, bus.sum}); end
`ifdef SERIAL_ADD_OVF_EN
        checks++; if (bus.ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", bus.ovf); end
`endif
        rst = 1'b0;
        mptr = 0;
    endtask

    // One request pattern from idle to completion; operands are disturbed right after the grant.
    task automatic test_single_op(input logic [1:0] r,
                                  input logic [W-1:0] x0, input logic [W-1:0] y0, input logic c0,
                                  input logic [W-1:0] x1, input logic [W-1:0] y1, input logic c1,
                                  input logic [W-1:0] late_a);
        int         gk, gcnt, bcnt, dk;
        logic       exp_id;
        logic [1:0] gval, exp_gnt;
        logic [W:0] exp_res, got_res;
        logic       got_id;
`ifdef SERIAL_ADD_OVF_EN
        logic       exp_ovf, got_ovf;
        got_ovf = 1'b0;
`endif
        exp_id  = (r == 2'b11) ? (mptr == 1) : r[1];
        exp_res = exp_id ? ref_add(x1, y1, c1) : ref_add(x0, y0, c0);
`ifdef SERIAL_ADD_OVF_EN
        exp_ovf = exp_id ? ref_ovf(x1, y1, c1) : ref_ovf(x0, y0, c0);
`endif
        exp_gnt = exp_id ? 2'b10 : 2'b01;
        gk = -1; dk = -1; gcnt = 0; bcnt = 0;
        gval = '0; got_res = '0; got_id = 1'b0;

        @(negedge clk);
        bus.a0 = x0; bus.b0 = y0; bus.cin0 = c0;
        bus.a1 = x1; bus.b1 = y1; bus.cin1 = c1;
        bus.req = r;
        for (int k = 1; k <= 4 * W; k++) begin
            @(negedge clk);
            if (bus.gnt != 2'b00) begin
                gcnt++;
                if (gk < 0) begin
                    gk = k; gval = bus.gnt;
                    bus.req = '0;
                    bus.a0 = late_a; bus.a1 = late_a;
                    bus.b0 = ~y0; bus.b1 = ~y1; bus.cin0 = ~c0; bus.cin1 = ~c1;
                end
            end
            if (bus.busy === 1'b1) bcnt++;
            if (bus.done === 1'b1) begin
                dk = k; got_res = {bus.cout, bus.sum}; got_id = bus.done_id;
`ifdef SERIAL_ADD_OVF_EN
                got_ovf = bus.ovf;
`endif
                break;
            end
        end
        mptr = exp_id ? 0 : 1;

        checks++; if (gval !== exp_gnt) begin errors++; $display("FAIL op_gnt: got %b want %b (req %b)", gval, exp_gnt, r); end
        checks++; if (gk != 1) begin errors++; $display("FAIL op_gnt_latency: got %0d want 1", gk); end
        checks++; if (gcnt != 1) begin errors++; $display("FAIL op_gnt_width: got %0d want 1", gcnt); end
        checks++; if (bcnt != W) begin errors++; $display("FAIL op_busy_cycles: got %0d want %0d", bcnt, W); end
        checks++; if (dk != W + 2) begin errors++; $display("FAIL op_done_latency: got %0d want %0d", dk, W + 2); end
        checks++; if (got_res !== exp_res) begin errors++; $display("FAIL op_result: got %h want %h", got_res, exp_res); end
        checks++; if (got_id !== exp_id) begin errors++; $display("FAIL op_done_id: got %b want %b", got_id, exp_id); end
`ifdef SERIAL_ADD_OVF_EN
        checks++; if (got_ovf !== exp_ovf) begin errors++; $display("FAIL op_ovf: got %b want %b", got_ovf, exp_ovf); end
`endif
        @(negedge clk);
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL op_done_pulse: got %b want 0", bus.done); end
        checks++; if ({bus.cout, bus.sum} !== exp_res) begin errors++; $display("FAIL op_result_hold: got %h want %h", {bus.cout, bus.sum}, exp_res); end
    endtask

    task automatic test_basic;
        test_single_op(2'b01, 8'h0F, 8'h01, 1'b0, 8'h33, 8'h44, 1'b0, 8'h55);
        test_single_op(2'b10, 8'h12, 8'h34, 1'b0, 8'hFF, 8'h01, 1'b1, 8'h00);
    endtask

    task automatic test_capture;
        test_single_op(2'b01, 8'h7F, 8'h01, 1'b0, 8'h00, 8'h00, 1'b0, 8'hAA);
    endtask

    task automatic test_random;
        for (int n = 0; n < 16; n++) begin
            test_single_op(2'($urandom_range(1, 3)),
                           W'($urandom), W'($urandom), 1'($urandom),
                           W'($urandom), W'($urandom), 1'($urandom),
                           W'($urandom));
        end
    endtask

    task automatic test_alternation;
        logic [W-1:0] oa[2], ob[2];
        logic         oc[2];
        logic         q_id[$];
        logic [W:0]   q_res[$];
        int           ndone, last_done;
        logic         eid;
        for (int i = 0; i < 2; i++) begin oa[i] = W'($urandom); ob[i] = W'($urandom); oc[i] = 1'($urandom); end
        ndone = 0; last_done = -1;
        @(negedge clk);
        bus.a0 = oa[0]; bus.b0 = ob[0]; bus.cin0 = oc[0];
        bus.a1 = oa[1]; bus.b1 = ob[1]; bus.cin1 = oc[1];
        bus.req = 2'b11;
        for (int k = 1; k <= 8 * (W + 2); k++) begin
            @(negedge clk);
            if (bus.gnt != 2'b00) begin
                eid = (mptr == 1);
                checks++; if (bus.gnt !== (eid ? 2'b10 : 2'b01)) begin errors++; $display("FAIL alt_gnt: got %b want %b", bus.gnt, eid ? 2'b10 : 2'b01); end
                q_id.push_back(eid);
                q_res.push_back(ref_add(oa[eid], ob[eid], oc[eid]));
                mptr = eid ? 0 : 1;
                for (int i = 0; i < 2; i++) begin oa[i] = W'($urandom); ob[i] = W'($urandom); oc[i] = 1'($urandom); end
                bus.a0 = oa[0]; bus.b0 = ob[0]; bus.cin0 = oc[0];
                bus.a1 = oa[1]; bus.b1 = ob[1]; bus.cin1 = oc[1];
            end
            if (bus.done === 1'b1) begin
                if (q_id.size() == 0) begin
                    checks++; errors++; $display("FAIL alt_unexpected_done: got done with no grant outstanding");
                end else begin
                    eid = q_id.pop_front();
                    checks++; if (bus.done_id !== eid) begin errors++; $display("FAIL alt_done_id: got %b want %b", bus.done_id, eid); end
                    checks++; if ({bus.cout, bus.sum} !== q_res[0]) begin errors++; $display("FAIL alt_result: got %h want %h", {bus.cout, bus.sum}, q_res[0]); end
                    void'(q_res.pop_front());
                end
                if (last_done >= 0) begin
                    checks++; if (k - last_done != W + 2) begin errors++; $display("FAIL alt_done_gap: got %0d want %0d", k - last_done, W + 2); end
                end
                last_done = k;
                ndone++;
                if (ndone == 4) begin bus.req = '0; break; end
            end
        end
        bus.req = '0;
        checks++; if (ndone != 4) begin errors++; $display("FAIL alt_done_count: got %0d want 4", ndone); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid_run;
        int gk, ndone;
        gk = -1; ndone = 0;
        @(negedge clk);
        bus.a0 = W'($urandom); bus.b0 = W'($urandom); bus.cin0 = 1'b1;
        bus.req = 2'b01;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (bus.gnt != 2'b00) begin gk = k; break; end
        end
        bus.req = '0;
        checks++; if (gk != 1) begin errors++; $display("FAIL rst_run_gnt_latency: got %0d want 1", gk); end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (bus.gnt !== 2'b00) begin errors++; $display("FAIL rst_run_gnt: got %b want 00", bus.gnt); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_run_busy: got %b want 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL rst_run_done: got %b want 0", bus.done); end
        checks++; if (bus.done_id !== 1'b0) begin errors++; $display("FAIL rst_run_done_id: got %b want 0", bus.done_id); end
        checks++; if ({bus.cout, bus.sum} !== '0) begin errors++; $display("FAIL rst_run_sum: got %h want 0", {bus.cout, bus.sum}); end
        for (int k = 0; k < W + 4; k++) begin
            @(negedge clk);
            if (bus.done === 1'b1 || bus.busy === 1'b1) ndone++;
        end
        checks++; if (ndone != 0) begin errors++; $display("FAIL rst_run_no_done: got %0d active cycles want 0", ndone); end
        mptr = 0;
        test_single_op(2'b11, W'($urandom), W'($urandom), 1'b0, W'($urandom), W'($urandom), 1'b1, W'($urandom));
        test_single_op(2'b10, W'($urandom), W'($urandom), 1'b1, W'($urandom), W'($urandom), 1'b0, W'($urandom));
    endtask

    task automatic test_req_in_done;
        logic [W-1:0] x, y, x2, y2;
        int           gk, dk;
        x = W'($urandom); y = W'($urandom); x2 = W'($urandom); y2 = W'($urandom);
        gk = -1; dk = -1;
        @(negedge clk);
        bus.a0 = x; bus.b0 = y; bus.cin0 = 1'b0; bus.req = 2'b01;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (bus.gnt != 2'b00) begin gk = k; break; end
        end
        bus.req = '0;
        checks++; if (gk < 0) begin errors++; $display("FAIL done_win_first_gnt: got none want 01"); end
        for (int k = 1; k <= 2 * W; k++) begin
            if (bus.busy !== 1'b1) break;
            @(negedge clk);
        end
        bus.a0 = x2; bus.b0 = y2; bus.cin0 = 1'b1; bus.req = 2'b01;
        mptr = 1;
        @(negedge clk);
        checks++; if (bus.gnt !== 2'b00) begin errors++; $display("FAIL done_win_no_gnt: got %b want 00", bus.gnt); end
        checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL done_win_done: got %b want 1", bus.done); end
        checks++; if ({bus.cout, bus.sum} !== ref_add(x, y, 1'b0)) begin errors++; $display("FAIL done_win_result1: got %h want %h", {bus.cout, bus.sum}, ref_add(x, y, 1'b0)); end
        @(negedge clk);
        checks++; if (bus.gnt !== 2'b01) begin errors++; $display("FAIL done_win_gnt: got %b want 01", bus.gnt); end
        bus.req = '0;
        for (int k = 1; k <= 4 * W; k++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin dk = k; break; end
        end
        checks++; if (dk != W + 1) begin errors++; $display("FAIL done_win_latency2: got %0d want %0d", dk, W + 1); end
        checks++; if ({bus.cout, bus.sum} !== ref_add(x2, y2, 1'b1)) begin errors++; $display("FAIL done_win_result2: got %h want %h", {bus.cout, bus.sum}, ref_add(x2, y2, 1'b1)); end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        test_reset();
        test_basic();
        test_alternation();
        test_reset_mid_run();
        test_capture();
        test_req_in_done();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
